// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package hazard_pkg;
  typedef enum logic {RUN, LU_STALL} hz_state_t;
  localparam logic [4:0] REG_X0 = 5'd0;
  localparam int LAT_W = 3;
endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     count <= '0;
    else if (inc && count != '1) count <= count + CNT_W'(1);
  end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline; Mealy controls plus perf counters.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic             ex_redirect,
  input  logic             imem_ready,
  input  logic             dmem_stall,
  output logic             pc_retain,
  output logic             if_id_retain,
  output logic             flush_if_id,
  output logic             id_ex_retain,
  output logic             flush_id_ex,
  output logic             ex_mem_retain,
  output logic             flush_mem_wb,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] lu_cnt
);
  localparam logic [LAT_W-1:0] LU_INIT = LAT_W'(LOAD_LAT - 1);

  hz_state_t        state, state_nxt;
  logic [LAT_W-1:0] lu_left, lu_left_nxt;
  logic             lu_hit, flush_inc, lu_inc;

  always_comb begin
    lu_hit = ex_mem_read & ex_reg_write & (ex_rd != REG_X0) &
             ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
    pc_retain     = 1'b0;
    if_id_retain  = 1'b0;
    flush_if_id   = 1'b0;
    id_ex_retain  = 1'b0;
    flush_id_ex   = 1'b0;
    ex_mem_retain = 1'b0;
    flush_mem_wb  = 1'b0;
    flush_inc     = 1'b0;
    lu_inc        = 1'b0;
    state_nxt     = state;
    lu_left_nxt   = lu_left;
    // Controls are forced quiet while reset is held.
    if (rst) begin
      state_nxt = RUN;
    end else if (dmem_stall) begin
      pc_retain     = 1'b1;
      if_id_retain  = 1'b1;
      id_ex_retain  = 1'b1;
      ex_mem_retain = 1'b1;
      flush_mem_wb  = 1'b1;
    end else if (ex_redirect) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
      flush_inc   = 1'b1;
      state_nxt   = RUN;
      lu_left_nxt = '0;
    end else if (lu_hit || state == LU_STALL) begin
      pc_retain    = 1'b1;
      if_id_retain = 1'b1;
      flush_id_ex  = 1'b1;
      if (state == RUN) begin
        lu_inc = 1'b1;
        if (LOAD_LAT > 1) begin
          state_nxt   = LU_STALL;
          lu_left_nxt = LU_INIT;
        end
      end else begin
        lu_left_nxt = lu_left - LAT_W'(1);
        if (lu_left == LAT_W'(1)) state_nxt = RUN;
      end
    end else if (!imem_ready) begin
      pc_retain   = 1'b1;
      flush_if_id = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      lu_left <= '0;
    end else begin
      state   <= state_nxt;
      lu_left <= lu_left_nxt;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (.clk(clk), .rst(rst), .inc(pc_retain), .count(stall_cnt));
  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (.clk(clk), .rst(rst), .inc(flush_inc), .count(flush_cnt));
  sat_counter #(.CNT_W(CNT_W)) u_lu_cnt    (.clk(clk), .rst(rst), .inc(lu_inc),    .count(lu_cnt));
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: three instances (LOAD_LAT=1, LOAD_LAT=3, CNT_W=4) share one stimulus stream.
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_use_rs1, id_use_rs2, ex_mem_read, ex_reg_write, ex_redirect, imem_ready, dmem_stall;
  // {pc_retain, if_id_retain, flush_if_id, id_ex_retain, flush_id_ex, ex_mem_retain, flush_mem_wb}
  logic [6:0]  c1, c3, c4;
  logic [15:0] st1, fl1, lu1, st3, fl3, lu3;
  logic [3:0]  st4, fl4, lu4;

  localparam logic [6:0] NONE = 7'b0000000, LU = 7'b1100100, FRZ = 7'b1101011,
                         RDR  = 7'b0010100, IMEM = 7'b1010000;

  pipeline_hazard_ctrl #(.LOAD_LAT(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .ex_redirect(ex_redirect), .imem_ready(imem_ready), .dmem_stall(dmem_stall),
    .pc_retain(c1[6]), .if_id_retain(c1[5]), .flush_if_id(c1[4]), .id_ex_retain(c1[3]),
    .flush_id_ex(c1[2]), .ex_mem_retain(c1[1]), .flush_mem_wb(c1[0]),
    .stall_cnt(st1), .flush_cnt(fl1), .lu_cnt(lu1));
  pipeline_hazard_ctrl #(.LOAD_LAT(3), .CNT_W(16)) u3 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .ex_redirect(ex_redirect), .imem_ready(imem_ready), .dmem_stall(dmem_stall),
    .pc_retain(c3[6]), .if_id_retain(c3[5]), .flush_if_id(c3[4]), .id_ex_retain(c3[3]),
    .flush_id_ex(c3[2]), .ex_mem_retain(c3[1]), .flush_mem_wb(c3[0]),
    .stall_cnt(st3), .flush_cnt(fl3), .lu_cnt(lu3));
  pipeline_hazard_ctrl #(.LOAD_LAT(1), .CNT_W(4)) u4 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .ex_redirect(ex_redirect), .imem_ready(imem_ready), .dmem_stall(dmem_stall),
    .pc_retain(c4[6]), .if_id_retain(c4[5]), .flush_if_id(c4[4]), .id_ex_retain(c4[3]),
    .flush_id_ex(c4[2]), .ex_mem_retain(c4[1]), .flush_mem_wb(c4[0]),
    .stall_cnt(st4), .flush_cnt(fl4), .lu_cnt(lu4));

  typedef struct {
    logic [6:0] e1;
    logic [6:0] e3;
    string      tag;
  } exp_t;
  exp_t sb[$];
  int n_vec = 0, n_bad = 0;

  // Scoreboard consumer: one expected control set per cycle, checked mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_vec++;
      if ({c1, c3, c4} !== {e.e1, e.e3, e.e1}) begin
        n_bad++;
        $display("FAIL %s: ctrl got %b/%b/%b want %b/%b/%b", e.tag, c1, c3, c4, e.e1, e.e3, e.e1);
      end
    end
  end

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = 5'd0; ex_mem_read = 1'b0; ex_reg_write = 1'b0;
    ex_redirect = 1'b0; imem_ready = 1'b1; dmem_stall = 1'b0;
  endtask

  // lw x5 in EX, add x6,x5,x1 in ID
  task automatic hazard();
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd5;
    id_rs1 = 5'd5; id_use_rs1 = 1'b1; id_rs2 = 5'd1; id_use_rs2 = 1'b1;
  endtask

  task automatic step(input logic [6:0] e1, input logic [6:0] e3, input string tag);
    sb.push_back('{e1, e3, tag});
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    hazard(); imem_ready = 1'b0; dmem_stall = 1'b1; ex_redirect = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({c1, c3, c4} !== 21'd0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b/%b/%b want all 0", c1, c3, c4);
    end
    n_vec++;
    if ({st1, fl1, lu1, st3, fl3, lu3, st4, fl4, lu4} !== 108'd0) begin
      n_bad++; $display("FAIL reset_cnt: got st %0d/%0d/%0d fl %0d/%0d/%0d lu %0d/%0d/%0d want 0",
                        st1, st3, st4, fl1, fl3, fl4, lu1, lu3, lu4);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    idle();
  endtask

  task automatic test_load_use();
    test_reset();
    hazard();           step(LU, LU, "lu_c0");
    idle();             step(NONE, LU, "lu_c1");
                        step(NONE, LU, "lu_c2");
                        step(NONE, NONE, "lu_c3");
    n_vec++;
    if ({lu1, lu3, lu4, st1, st3, st4} !== {16'd1, 16'd1, 4'd1, 16'd1, 16'd3, 4'd1}) begin
      n_bad++; $display("FAIL lu_counts: lu %0d/%0d/%0d st %0d/%0d/%0d want lu 1/1/1 st 1/3/1",
                        lu1, lu3, lu4, st1, st3, st4);
    end
  endtask

  task automatic test_no_hazard();
    test_reset();
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
    step(NONE, NONE, "nh_x0");
    ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b0; id_rs2 = 5'd3; id_use_rs2 = 1'b1;
    step(NONE, NONE, "nh_unused_rs1");
    id_use_rs1 = 1'b1; ex_reg_write = 1'b0;
    step(NONE, NONE, "nh_no_wr");
    ex_reg_write = 1'b1; ex_mem_read = 1'b0;
    step(NONE, NONE, "nh_not_load");
    n_vec++;
    if ({lu1, lu3, lu4, st1, st3} !== 36'd0) begin
      n_bad++; $display("FAIL nh_counts: lu %0d/%0d/%0d st %0d/%0d want 0", lu1, lu3, lu4, st1, st3);
    end
    ex_mem_read = 1'b1; id_rs1 = 5'd2; id_rs2 = 5'd7;
    step(LU, LU, "rs2_hit");
    idle();
    step(NONE, LU, "rs2_c1");
    step(NONE, LU, "rs2_c2");
    step(NONE, NONE, "rs2_c3");
    n_vec++;
    if ({lu1, lu3} !== {16'd1, 16'd1}) begin
      n_bad++; $display("FAIL rs2_lu_cnt: got %0d/%0d want 1/1", lu1, lu3);
    end
  endtask

  task automatic test_freeze();
    test_reset();
    hazard(); step(LU, LU, "fz_hit");
    idle(); dmem_stall = 1'b1; ex_redirect = 1'b1;
    step(FRZ, FRZ, "fz_0");
    step(FRZ, FRZ, "fz_1");
    ex_redirect = 1'b0;
    step(FRZ, FRZ, "fz_2");
    step(FRZ, FRZ, "fz_3");
    dmem_stall = 1'b0;
    step(NONE, LU, "fz_rel0");
    step(NONE, LU, "fz_rel1");
    step(NONE, NONE, "fz_done");
    n_vec++;
    if ({st1, st3, st4, fl1, fl3, lu1, lu3} !== {16'd5, 16'd7, 4'd5, 16'd0, 16'd0, 16'd1, 16'd1}) begin
      n_bad++; $display("FAIL fz_counts: st %0d/%0d/%0d fl %0d/%0d lu %0d/%0d want st 5/7/5 fl 0/0 lu 1/1",
                        st1, st3, st4, fl1, fl3, lu1, lu3);
    end
  endtask

  task automatic test_redirect();
    test_reset();
    hazard(); ex_redirect = 1'b1; imem_ready = 1'b0;
    step(RDR, RDR, "rd_coincident");
    idle();
    step(NONE, NONE, "rd_after");
    n_vec++;
    if ({fl1, fl3, lu1, lu3, st1, st3} !== {16'd1, 16'd1, 64'd0}) begin
      n_bad++; $display("FAIL rd_counts: fl %0d/%0d lu %0d/%0d st %0d/%0d want fl 1/1 lu 0 st 0",
                        fl1, fl3, lu1, lu3, st1, st3);
    end
    hazard(); step(LU, LU, "rd_lu_hit");
    idle(); ex_redirect = 1'b1;
    step(RDR, RDR, "rd_cancel");
    idle();
    step(NONE, NONE, "rd_cancelled");
    n_vec++;
    if ({fl3, lu3, st3} !== {16'd2, 16'd1, 16'd1}) begin
      n_bad++; $display("FAIL rd_cancel_counts: fl %0d lu %0d st %0d want 2/1/1", fl3, lu3, st3);
    end
  endtask

  task automatic test_imem_sat();
    test_reset();
    imem_ready = 1'b0;
    for (int i = 0; i < 20; i++) step(IMEM, IMEM, "imem_wait");
    n_vec++;
    if ({st1, st3, st4} !== {16'd20, 16'd20, 4'd15}) begin
      n_bad++; $display("FAIL imem_sat: st %0d/%0d/%0d want 20/20/15", st1, st3, st4);
    end
    imem_ready = 1'b1; hazard();
    step(LU, LU, "sat_hit");
    n_vec++;
    if ({st1, st4, lu4} !== {16'd21, 4'd15, 4'd1}) begin
      n_bad++; $display("FAIL sat_hold: st %0d/%0d lu4 %0d want 21/15/1", st1, st4, lu4);
    end
    test_reset();
    step(NONE, NONE, "post_rst_idle");
    n_vec++;
    if ({st1, st3, st4, lu3} !== 52'd0) begin
      n_bad++; $display("FAIL post_rst_cnt: st %0d/%0d/%0d lu3 %0d want 0", st1, st3, st4, lu3);
    end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_load_use();
    test_no_hazard();
    test_freeze();
    test_redirect();
    test_imem_sat();
    @(negedge clk); #1;
    if (sb.size() != 0) begin
      n_bad++; $display("FAIL sb_drain: %0d entries left want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
